// File: rtl/data_mem_responder_pkg.sv
// Shared CPU definitions: word width, memory opcodes, CPU stage encoding and
// the data-memory responder state encoding.
package cpu_defs;

  localparam int WORD_W = 32;

  typedef enum logic [5:0] {
    OP_LW = 6'h23,
    OP_SW = 6'h2B
  } mem_opcode_t;

  typedef enum logic [2:0] {
    STG_FETCH     = 3'd0,
    STG_DECODE    = 3'd1,
    STG_EXECUTE   = 3'd2,
    STG_MEMORY    = 3'd3,
    STG_WRITEBACK = 3'd4
  } cpu_stage_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } rsp_state_t;

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Single-port synchronous word RAM. Contents have no reset; a read returns the
// word as it was before any same-edge write.
module dmem_array
  import cpu_defs::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // one access per enabled edge: optional write plus registered read
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[idx] <= wdata;
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the CPU Memory stage. Accepts one LW/SW at a time,
// waits LATENCY cycles, commits/reads the RAM on the edge entering RESPOND and
// presents a registered response one cycle later.
//
// state   | meaning
// IDLE    | ready for a request; accepts on req_valid
// WAIT    | counting down the access latency
// RESPOND | RAM accessed; response registered and held until resp_ready
module data_mem_responder
  import cpu_defs::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WORD_W-1:0]     req_wdata,
  output logic                  req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WORD_W-1:0]     resp_rdata,
  output logic                  resp_error
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW    = ADDR_WIDTH - 2;
  localparam logic [IW:0] DEPTH_W = (IW+1)'(DEPTH);
  localparam logic [3:0]  LAT4    = 4'(LATENCY);

  rsp_state_t state, stateNext;
  logic [3:0] waitCnt, waitCntNext;

  logic                  writeQ;
  logic                  errQ;
  logic [ADDR_WIDTH-1:0] addrQ;
  logic [WORD_W-1:0]     wdataQ;

  logic                  respValidQ;
  logic [WORD_W-1:0]     respRdataQ;
  logic                  respErrorQ;

  logic                  accessWrite;
  logic [ADDR_WIDTH-1:0] accessAddr;
  logic [WORD_W-1:0]     accessWdata;
  logic                  accessErr;
  logic                  enteringRespond;
  logic                  ramEn;
  logic                  ramWe;
  logic [WORD_W-1:0]     ramRdata;

  // In IDLE the RAM is addressed straight from the request so a zero-latency
  // access can commit on the accepting edge; otherwise from the latched copy.
  always_comb begin
    accessWrite = writeQ;
    accessAddr  = addrQ;
    accessWdata = wdataQ;
    if (state == IDLE) begin
      accessWrite = req_write;
      accessAddr  = req_addr;
      accessWdata = req_wdata;
    end
    accessErr = (accessAddr[1:0] != 2'b00) ||
                ({1'b0, accessAddr[ADDR_WIDTH-1:2]} >= DEPTH_W);
    enteringRespond = ((state == IDLE) && req_valid && (LAT4 == 4'd0)) ||
                      ((state == WAIT) && (waitCnt == 4'd1));
    ramEn = enteringRespond && !accessErr && !reset;
    ramWe = ramEn && accessWrite;
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_dmem_array (
    .clk   (clk),
    .en    (ramEn),
    .we    (ramWe),
    .idx   (accessAddr[IDX_W+1:2]),
    .wdata (accessWdata),
    .rdata (ramRdata)
  );

  // next-state and latency counter
  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (LAT4 == 4'd0) begin
            stateNext = RESPOND;
          end else begin
            stateNext   = WAIT;
            waitCntNext = LAT4;
          end
        end
      end
      WAIT: begin
        if (waitCnt == 4'd1) begin
          stateNext   = RESPOND;
          waitCntNext = 4'd0;
        end else begin
          waitCntNext = waitCnt - 4'd1;
        end
      end
      RESPOND: begin
        if (respValidQ && resp_ready) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext   = IDLE;
        waitCntNext = 4'd0;
      end
    endcase
  end

  // state, counter and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      waitCnt    <= 4'd0;
      respValidQ <= 1'b0;
      respRdataQ <= '0;
      respErrorQ <= 1'b0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      if ((state == RESPOND) && !respValidQ) begin
        respValidQ <= 1'b1;
        respErrorQ <= errQ;
        respRdataQ <= (errQ || writeQ) ? '0 : ramRdata;
      end else if (respValidQ && resp_ready) begin
        respValidQ <= 1'b0;
        respRdataQ <= '0;
        respErrorQ <= 1'b0;
      end
    end
  end

  // capture the request on acceptance; abandoned by reset via the state register
  always_ff @(posedge clk) begin
    if ((state == IDLE) && req_valid) begin
      writeQ <= req_write;
      addrQ  <= req_addr;
      wdataQ <= req_wdata;
      errQ   <= accessErr;
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = respValidQ;
  assign resp_rdata = respRdataQ;
  assign resp_error = respErrorQ;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: instance A (ADDR_WIDTH=11, LATENCY=2) and
// instance B (defaults, LATENCY=0), checked against a word-array model.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        reqValid, reqWrite, reqReady, respValid, respReady, respError;
  logic [10:0] reqAddr;
  logic [31:0] reqWdata, respRdata;

  logic        bReqValid, bReqWrite, bReqReady, bRespValid, bRespReady, bRespError;
  logic [9:0]  bReqAddr;
  logic [31:0] bReqWdata, bRespRdata;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] modelMem [256];
  bit          modelKnown [256];

  data_mem_responder #(.ADDR_WIDTH(11), .DEPTH(256), .LATENCY(2)) dutA (
    .clk(clk), .reset(reset),
    .req_valid(reqValid), .req_write(reqWrite), .req_addr(reqAddr), .req_wdata(reqWdata),
    .req_ready(reqReady), .resp_valid(respValid), .resp_ready(respReady),
    .resp_rdata(respRdata), .resp_error(respError)
  );

  data_mem_responder #(.ADDR_WIDTH(10), .DEPTH(256), .LATENCY(0)) dutB (
    .clk(clk), .reset(reset),
    .req_valid(bReqValid), .req_write(bReqWrite), .req_addr(bReqAddr), .req_wdata(bReqWdata),
    .req_ready(bReqReady), .resp_valid(bRespValid), .resp_ready(bRespReady),
    .resp_rdata(bRespRdata), .resp_error(bRespError)
  );

  function automatic logic rdy(input int inst);
    return (inst != 0) ? bReqReady : reqReady;
  endfunction

  function automatic logic vld(input int inst);
    return (inst != 0) ? bRespValid : respValid;
  endfunction

  task automatic drive(input int inst, input logic v, input logic w,
                       input logic [10:0] a, input logic [31:0] d);
    if (inst == 0) begin
      reqValid = v; reqWrite = w; reqAddr = a; reqWdata = d;
    end else begin
      bReqValid = v; bReqWrite = w; bReqAddr = a[9:0]; bReqWdata = d;
    end
  endtask

  task automatic setResp(input int inst, input logic r);
    if (inst == 0) respReady = r;
    else bRespReady = r;
  endtask

  // One transaction: lat = cycles from the accepting edge to resp_valid seen high.
  task automatic doReq(input int inst, input logic wr, input logic [10:0] addr,
                       input logic [31:0] wd, input int stall,
                       output logic [31:0] rd, output logic er, output int lat, output bit ok);
    int n;
    ok = 1'b1; rd = '0; er = 1'b0; lat = 0; n = 0;
    setResp(inst, stall == 0);
    while (!rdy(inst) && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) ok = 1'b0;
    drive(inst, 1'b1, wr, addr, wd);
    @(posedge clk); #1;
    drive(inst, 1'b0, 1'b0, '0, '0);
    while (!vld(inst) && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!vld(inst)) ok = 1'b0;
    rd = (inst != 0) ? bRespRdata : respRdata;
    er = (inst != 0) ? bRespError : respError;
    for (int i = 0; i < stall; i++) begin @(posedge clk); #1; end
    setResp(inst, 1'b1);
    @(posedge clk); #1;
    setResp(inst, 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    compared++; if (reqReady !== 1'b1) begin mismatched++; $display("FAIL reset_req_ready: got %b expected 1", reqReady); end
    compared++; if (respValid !== 1'b0) begin mismatched++; $display("FAIL reset_resp_valid: got %b expected 0", respValid); end
    compared++; if (respRdata !== 32'h0) begin mismatched++; $display("FAIL reset_resp_rdata: got %h expected 0", respRdata); end
    compared++; if (respError !== 1'b0) begin mismatched++; $display("FAIL reset_resp_error: got %b expected 0", respError); end
    compared++; if (bReqReady !== 1'b1 || bRespValid !== 1'b0) begin mismatched++; $display("FAIL reset_b: got ready=%b valid=%b expected 1 0", bReqReady, bRespValid); end
  endtask

  task automatic test_store_load;
    logic [31:0] rd; logic er; int lat; bit ok;
    doReq(0, 1'b1, 11'h010, 32'hDEADBEEF, 0, rd, er, lat, ok);
    modelMem[4] = 32'hDEADBEEF; modelKnown[4] = 1'b1;
    compared++; if (!ok) begin mismatched++; $display("FAIL sw_timeout: got timeout expected response"); end
    compared++; if (lat != 3) begin mismatched++; $display("FAIL sw_latency: got %0d expected 3", lat); end
    compared++; if (er !== 1'b0 || rd !== 32'h0) begin mismatched++; $display("FAIL sw_resp: got err=%b rdata=%h expected 0 0", er, rd); end
    doReq(0, 1'b0, 11'h010, 32'h0, 0, rd, er, lat, ok);
    compared++; if (lat != 3 || !ok) begin mismatched++; $display("FAIL lw_latency: got %0d expected 3", lat); end
    compared++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin mismatched++; $display("FAIL lw_resp: got err=%b rdata=%h expected 0 deadbeef", er, rd); end
  endtask

  task automatic test_misaligned;
    logic [31:0] rd; logic er; int lat; bit ok;
    doReq(0, 1'b1, 11'h012, 32'h12345678, 0, rd, er, lat, ok);
    compared++; if (!ok || er !== 1'b1 || rd !== 32'h0) begin mismatched++; $display("FAIL misaligned_sw: got err=%b rdata=%h expected 1 0", er, rd); end
    doReq(0, 1'b0, 11'h010, 32'h0, 0, rd, er, lat, ok);
    compared++; if (!ok || er !== 1'b0 || rd !== 32'hDEADBEEF) begin mismatched++; $display("FAIL after_misaligned_lw: got err=%b rdata=%h expected 0 deadbeef", er, rd); end
  endtask

  task automatic test_out_of_range;
    logic [31:0] rd; logic er; int lat; bit ok;
    doReq(0, 1'b1, 11'h3FC, 32'h0BADCAFE, 0, rd, er, lat, ok);
    modelMem[255] = 32'h0BADCAFE; modelKnown[255] = 1'b1;
    doReq(0, 1'b0, 11'h3FC, 32'h0, 0, rd, er, lat, ok);
    compared++; if (!ok || er !== 1'b0 || rd !== 32'h0BADCAFE) begin mismatched++; $display("FAIL last_word_lw: got err=%b rdata=%h expected 0 0badcafe", er, rd); end
    doReq(0, 1'b0, 11'h400, 32'h0, 0, rd, er, lat, ok);
    compared++; if (!ok || er !== 1'b1 || rd !== 32'h0) begin mismatched++; $display("FAIL oor_lw_400: got err=%b rdata=%h expected 1 0", er, rd); end
    doReq(0, 1'b1, 11'h404, 32'h55AA55AA, 0, rd, er, lat, ok);
    compared++; if (!ok || er !== 1'b1 || rd !== 32'h0) begin mismatched++; $display("FAIL oor_sw_404: got err=%b rdata=%h expected 1 0", er, rd); end
    doReq(0, 1'b0, 11'h7FC, 32'h0, 0, rd, er, lat, ok);
    compared++; if (!ok || er !== 1'b1 || rd !== 32'h0) begin mismatched++; $display("FAIL oor_lw_7fc: got err=%b rdata=%h expected 1 0", er, rd); end
  endtask

  task automatic test_backpressure;
    int n;
    respReady = 1'b0;
    n = 0;
    while (!reqReady && n < 50) begin @(posedge clk); #1; n++; end
    drive(0, 1'b1, 1'b0, 11'h010, 32'h0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, '0, '0);
    n = 0;
    while (!respValid && n < 50) begin @(posedge clk); #1; n++; end
    compared++; if (n != 3) begin mismatched++; $display("FAIL bp_latency: got %0d expected 3", n); end
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (respValid !== 1'b1 || respRdata !== 32'hDEADBEEF || reqReady !== 1'b0) begin
        mismatched++;
        $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h ready=%b expected 1 deadbeef 0", i, respValid, respRdata, reqReady);
      end
      @(posedge clk); #1;
    end
    respReady = 1'b1;
    @(posedge clk); #1;
    respReady = 1'b0;
    compared++; if (respValid !== 1'b0 || reqReady !== 1'b1) begin mismatched++; $display("FAIL bp_release: got valid=%b ready=%b expected 0 1", respValid, reqReady); end
    @(posedge clk); #1;
    compared++; if (respValid !== 1'b0) begin mismatched++; $display("FAIL bp_single: got valid=%b expected 0", respValid); end
  endtask

  task automatic test_reset_midop;
    logic [31:0] rd; logic er; int lat; bit ok; int n;
    doReq(0, 1'b1, 11'h020, 32'h11112222, 0, rd, er, lat, ok);
    modelMem[8] = 32'h11112222; modelKnown[8] = 1'b1;
    n = 0;
    while (!reqReady && n < 50) begin @(posedge clk); #1; n++; end
    drive(0, 1'b1, 1'b1, 11'h020, 32'hCAFEF00D);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    compared++; if (reqReady !== 1'b1 || respValid !== 1'b0) begin mismatched++; $display("FAIL midop_idle: got ready=%b valid=%b expected 1 0", reqReady, respValid); end
    repeat (4) @(posedge clk);
    #1;
    compared++; if (respValid !== 1'b0) begin mismatched++; $display("FAIL midop_no_resp: got valid=%b expected 0", respValid); end
    doReq(0, 1'b0, 11'h020, 32'h0, 0, rd, er, lat, ok);
    compared++; if (!ok || er !== 1'b0 || rd !== 32'h11112222) begin mismatched++; $display("FAIL midop_lw: got err=%b rdata=%h expected 0 11112222", er, rd); end
  endtask

  task automatic test_back_to_back;
    int accepts; int lastAccept; int n;
    accepts = 0; lastAccept = -1;
    respReady = 1'b1;
    drive(0, 1'b1, 1'b0, 11'h010, 32'h0);
    for (int i = 0; i < 20; i++) begin
      if (reqReady) begin
        if (lastAccept >= 0) begin
          compared++;
          if (i - lastAccept != 5) begin mismatched++; $display("FAIL b2b_spacing: got %0d expected 5", i - lastAccept); end
        end
        lastAccept = i;
        accepts++;
      end
      if (respValid) begin
        compared++;
        if (respRdata !== 32'hDEADBEEF) begin mismatched++; $display("FAIL b2b_rdata: got %h expected deadbeef", respRdata); end
      end
      @(posedge clk); #1;
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    compared++; if (accepts != 4) begin mismatched++; $display("FAIL b2b_count: got %0d expected 4", accepts); end
    n = 0;
    while (!reqReady && n < 20) begin @(posedge clk); #1; n++; end
    respReady = 1'b0;
  endtask

  task automatic test_random;
    logic [31:0] rd; logic er; int lat; bit ok;
    logic [10:0] addr; logic wr; logic [31:0] wd; int stall; int a; int sel;
    logic expErr; logic [31:0] expRd; bit checkRd;
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5)      a = 4 * $urandom_range(0, 15);
      else if (sel == 6) a = 4 * $urandom_range(250, 270);
      else if (sel == 7) a = 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
      else if (sel == 8) a = $urandom_range(0, 2047);
      else               a = 4 * $urandom_range(255, 256);
      addr  = 11'(a);
      wr    = 1'($urandom_range(0, 1));
      wd    = $urandom;
      stall = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      expErr = ((a % 4) != 0) || ((a / 4) >= 256);
      checkRd = 1'b1;
      expRd = 32'h0;
      if (!expErr && !wr) begin
        if (modelKnown[a / 4]) expRd = modelMem[a / 4];
        else checkRd = 1'b0;
      end
      doReq(0, wr, addr, wd, stall, rd, er, lat, ok);
      if (!expErr && wr) begin modelMem[a / 4] = wd; modelKnown[a / 4] = 1'b1; end
      compared++;
      if (!ok || lat != 3) begin mismatched++; $display("FAIL rnd_latency[%0d]: got %0d ok=%0d expected 3", t, lat, ok); end
      compared++;
      if (er !== expErr) begin mismatched++; $display("FAIL rnd_error[%0d] addr=%h: got %b expected %b", t, addr, er, expErr); end
      if (checkRd) begin
        compared++;
        if (rd !== expRd) begin mismatched++; $display("FAIL rnd_rdata[%0d] addr=%h wr=%b: got %h expected %h", t, addr, wr, rd, expRd); end
      end
    end
  endtask

  task automatic test_latency0;
    logic [31:0] rd; logic er; int lat; bit ok;
    doReq(1, 1'b1, 11'h010, 32'hA5A55A5A, 0, rd, er, lat, ok);
    compared++; if (!ok || lat != 1) begin mismatched++; $display("FAIL l0_sw_latency: got %0d expected 1", lat); end
    compared++; if (er !== 1'b0 || rd !== 32'h0) begin mismatched++; $display("FAIL l0_sw_resp: got err=%b rdata=%h expected 0 0", er, rd); end
    doReq(1, 1'b0, 11'h010, 32'h0, 2, rd, er, lat, ok);
    compared++; if (!ok || lat != 1) begin mismatched++; $display("FAIL l0_lw_latency: got %0d expected 1", lat); end
    compared++; if (er !== 1'b0 || rd !== 32'hA5A55A5A) begin mismatched++; $display("FAIL l0_lw_resp: got err=%b rdata=%h expected 0 a5a55a5a", er, rd); end
    doReq(1, 1'b1, 11'h016, 32'h77777777, 0, rd, er, lat, ok);
    compared++; if (!ok || er !== 1'b1 || rd !== 32'h0) begin mismatched++; $display("FAIL l0_misaligned: got err=%b rdata=%h expected 1 0", er, rd); end
    doReq(1, 1'b0, 11'h014, 32'h0, 0, rd, er, lat, ok);
    compared++; if (!ok || er !== 1'b0 || rd === 32'h77777777) begin mismatched++; $display("FAIL l0_no_write_on_err: got err=%b rdata=%h expected 0 not 77777777", er, rd); end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    respReady = 1'b0;
    bRespReady = 1'b0;
    for (int i = 0; i < 256; i++) begin modelMem[i] = '0; modelKnown[i] = 1'b0; end
    test_reset();
    test_store_load();
    test_misaligned();
    test_out_of_range();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    test_random();
    test_latency0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
